// File: rtl/seq_restoring_divider_if.sv
// Handshake and operand/result bundle between the control unit and the
// sequential restoring divider. The control unit drives through the master
// modport and the divider responds through the slave modport.
interface seq_restoring_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, dividend, divisor,
    input  busy, done, div_by_zero, quotient, remainder
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, div_by_zero, quotient, remainder
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider for the DIV instruction. One quotient bit is
// retired per clock. Results are held on quotient/remainder until the next
// accepted start, and a one-cycle done pulse marks them valid.
// Optional signed (truncating) mode is enabled by defining DIV_SIGNED_EN,
// which adds a one-cycle sign-fix state after the iterations.
module seq_restoring_divider #(
  parameter int WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   clr_i,
  seq_restoring_divider_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd3;
`ifdef DIV_SIGNED_EN
  localparam logic [1:0] S_FIX  = 2'd2;
`endif

  logic [1:0]       state_q, state_d;
  logic [WIDTH:0]   partRem_q, partRem_d;
  logic [WIDTH-1:0] quoShift_q, quoShift_d;
  logic [WIDTH-1:0] divisorReg_q, divisorReg_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             divZero_q, divZero_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
`ifdef DIV_SIGNED_EN
  logic             negQuo_q, negQuo_d;
  logic             negRem_q, negRem_d;
`endif

  logic [WIDTH-1:0] dividendMag;
  logic [WIDTH-1:0] divisorMag;
  logic [WIDTH+1:0] trial;

  // Operand magnitudes fed into the unsigned core (identity when unsigned)
  always_comb begin
`ifdef DIV_SIGNED_EN
    dividendMag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    divisorMag  = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
`else
    dividendMag = bus.dividend;
    divisorMag  = bus.divisor;
`endif
  end

  // Next-state logic: operand capture, shift/subtract/restore, sign fix, result latch
  always_comb begin
    state_d      = state_q;
    partRem_d    = partRem_q;
    quoShift_d   = quoShift_q;
    divisorReg_d = divisorReg_q;
    count_d      = count_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    divZero_d    = divZero_q;
    quotient_d   = quotient_q;
    remainder_d  = remainder_q;
`ifdef DIV_SIGNED_EN
    negQuo_d     = negQuo_q;
    negRem_d     = negRem_q;
`endif
    trial = {partRem_q, quoShift_q[WIDTH-1]} - {2'b00, divisorReg_q};

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (bus.start && !busy_q) begin
          busy_d       = 1'b1;
          divZero_d    = 1'b0;
          partRem_d    = '0;
          divisorReg_d = divisorMag;
          count_d      = CNT_W'(WIDTH);
`ifdef DIV_SIGNED_EN
          negQuo_d     = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
          negRem_d     = bus.dividend[WIDTH-1];
`endif
          if (bus.divisor == '0) begin
            quoShift_d = bus.dividend;
            state_d    = S_DONE;
          end else begin
            quoShift_d = dividendMag;
            state_d    = S_RUN;
          end
        end
      end

      S_RUN: begin
        count_d = count_q - CNT_W'(1);
        if (trial[WIDTH+1]) begin
          partRem_d  = {partRem_q[WIDTH-1:0], quoShift_q[WIDTH-1]};
          quoShift_d = {quoShift_q[WIDTH-2:0], 1'b0};
        end else begin
          partRem_d  = trial[WIDTH:0];
          quoShift_d = {quoShift_q[WIDTH-2:0], 1'b1};
        end
        if (count_q == CNT_W'(1)) begin
`ifdef DIV_SIGNED_EN
          state_d = S_FIX;
`else
          state_d = S_DONE;
`endif
        end
      end

`ifdef DIV_SIGNED_EN
      S_FIX: begin
        quoShift_d = negQuo_q ? -quoShift_q : quoShift_q;
        partRem_d  = {1'b0, negRem_q ? -partRem_q[WIDTH-1:0] : partRem_q[WIDTH-1:0]};
        state_d    = S_DONE;
      end
`endif

      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (divisorReg_q == '0) begin
          quotient_d  = '1;
          remainder_d = quoShift_q;
          divZero_d   = 1'b1;
        end else begin
          quotient_d  = quoShift_q;
          remainder_d = partRem_q[WIDTH-1:0];
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous clear
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      state_q      <= S_IDLE;
      partRem_q    <= '0;
      quoShift_q   <= '0;
      divisorReg_q <= '0;
      count_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      divZero_q    <= 1'b0;
      quotient_q   <= '0;
      remainder_q  <= '0;
`ifdef DIV_SIGNED_EN
      negQuo_q     <= 1'b0;
      negRem_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      partRem_q    <= partRem_d;
      quoShift_q   <= quoShift_d;
      divisorReg_q <= divisorReg_d;
      count_q      <= count_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      divZero_q    <= divZero_d;
      quotient_q   <= quotient_d;
      remainder_q  <= remainder_d;
`ifdef DIV_SIGNED_EN
      negQuo_q     <= negQuo_d;
      negRem_q     <= negRem_d;
`endif
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = divZero_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Testbench for seq_restoring_divider (WIDTH=32). A cycle-level behavioural
// model computes results with plain arithmetic and tracks when done/busy must
// move; every cycle the outputs are compared against it. Directed vectors with
// literal expectations pin the model. Honours DIV_SIGNED_EN like the design.
module tb_seq_restoring_divider;

  localparam int W = 32;
`ifdef DIV_SIGNED_EN
  localparam int RUN_LAT = W + 2;
`else
  localparam int RUN_LAT = W + 1;
`endif
  localparam int START_TO_DONE = RUN_LAT + 1;

  logic clk;
  logic clr;

  seq_restoring_divider_if #(.WIDTH(W)) bus ();

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk_i (clk),
    .clr_i (clr),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic for one accepted division
  task automatic modelDivide(input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] q, output logic [31:0] r,
                             output logic dz, output int lat);
    longint sa;
    longint sb;
    if (b == 32'd0) begin
      q   = 32'hFFFF_FFFF;
      r   = a;
      dz  = 1'b1;
      lat = 1;
    end else begin
      dz  = 1'b0;
      lat = RUN_LAT;
`ifdef DIV_SIGNED_EN
      sa = longint'($signed(a));
      sb = longint'($signed(b));
`else
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
`endif
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
  endtask

  // Behavioural model state, advanced on every rising edge
  int          edgeCnt   = 0;
  int          doneEdge  = -1;
  int          freeEdge  = -1;
  bit          modelLive = 1'b0;
  logic        expBusy, expDone, expDz;
  logic [31:0] expQ, expR;
  logic [31:0] pendQ, pendR;
  logic        pendDz;

  always @(posedge clk) begin
    int lat;
    edgeCnt++;
    if (clr) begin
      modelLive = 1'b1;
      expBusy   = 1'b0;
      expDone   = 1'b0;
      expDz     = 1'b0;
      expQ      = '0;
      expR      = '0;
      doneEdge  = -1;
      freeEdge  = -1;
    end else if (modelLive) begin
      expDone = (edgeCnt == doneEdge);
      if (expDone) begin
        expQ  = pendQ;
        expR  = pendR;
        expDz = pendDz;
      end
      if (edgeCnt == freeEdge) begin
        expBusy = 1'b0;
      end else if (!expBusy && bus.start) begin
        modelDivide(bus.dividend, bus.divisor, pendQ, pendR, pendDz, lat);
        expBusy  = 1'b1;
        expDz    = 1'b0;
        doneEdge = edgeCnt + lat;
        freeEdge = doneEdge + 1;
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (modelLive) begin
      checkVal("busy", bus.busy, expBusy);
      checkVal("done", bus.done, expDone);
      checkVal("div_by_zero", bus.div_by_zero, expDz);
      checkVal("quotient", bus.quotient, expQ);
      checkVal("remainder", bus.remainder, expR);
    end
  end

  // Pulse start for one cycle, then scramble operands to prove they were captured
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
  endtask

  // Count cycles (starting at 1 in the cycle after the start cycle) until done
  task automatic waitDone(input string name, output int n);
    n = 1;
    while (bus.done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.done !== 1'b1) checkVal({name, "_timeout"}, bus.done, 32'd1);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] q, input logic [31:0] r, input logic dz);
    checkVal({name, "_q"}, bus.quotient, q);
    checkVal({name, "_r"}, bus.remainder, r);
    checkVal({name, "_dz"}, bus.div_by_zero, dz);
  endtask

  initial begin
    int n;
    clr          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    checkVal("reset_busy", bus.busy, 32'd0);
    checkVal("reset_done", bus.done, 32'd0);
    checkOutput("reset", 32'd0, 32'd0, 1'b0);

    applyStimulus(32'd100, 32'd7);
    checkVal("run_busy", bus.busy, 32'd1);
    waitDone("d100_7", n);
    checkVal("d100_7_latency", n, START_TO_DONE);
    checkOutput("d100_7", 32'd14, 32'd2, 1'b0);

    applyStimulus(32'd5, 32'd0);
    waitDone("dz", n);
    applyStimulus(32'h0000_1234, 32'd0);
    waitDone("dz1234", n);
    checkVal("dz1234_latency", n, 32'd2);
    checkOutput("dz1234", 32'hFFFF_FFFF, 32'h0000_1234, 1'b1);

    applyStimulus(32'hFFFF_FFFF, 32'd1);
    checkVal("dz_cleared", bus.div_by_zero, 32'd0);
    waitDone("dmax_1", n);
    checkOutput("dmax_1", 32'hFFFF_FFFF, 32'd0, 1'b0);

    applyStimulus(32'd5, 32'hFFFF_FFFF);
    waitDone("d5_max", n);
`ifdef DIV_SIGNED_EN
    checkOutput("d5_max", 32'hFFFF_FFFB, 32'd0, 1'b0);
`else
    checkOutput("d5_max", 32'd0, 32'd5, 1'b0);
`endif

`ifdef DIV_SIGNED_EN
    applyStimulus(-32'sd100, 32'd7);
    waitDone("dneg100_7", n);
    checkVal("dneg100_7_latency", n, 32'd35);
    checkOutput("dneg100_7", 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);

    applyStimulus(32'd100, -32'sd7);
    waitDone("d100_neg7", n);
    checkOutput("d100_neg7", 32'hFFFF_FFF2, 32'd2, 1'b0);

    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF);
    waitDone("dmostneg", n);
    checkOutput("dmostneg", 32'h8000_0000, 32'd0, 1'b0);
`else
    checkVal("unsigned_latency", START_TO_DONE, 32'd34);
`endif

    // Clear part-way through a division: abandoned with no done
    applyStimulus(32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checkVal("clr_busy", bus.busy, 32'd0);
    checkVal("clr_done", bus.done, 32'd0);
    checkOutput("clr", 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkVal("clr_no_done", bus.done, 32'd0);
    end
    applyStimulus(32'd1000, 32'd3);
    waitDone("d1000_3", n);
    checkOutput("d1000_3", 32'd333, 32'd1, 1'b0);

    // Start re-pulsed while busy is ignored
    applyStimulus(32'd200, 32'd9);
    repeat (4) @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 32'd50;
    bus.divisor  = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    waitDone("d200_9", n);
    checkOutput("d200_9", 32'd22, 32'd2, 1'b0);

    // Start held through the done cycle: second division accepted one cycle later
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 32'd77;
    bus.divisor  = 32'd5;
    @(negedge clk);
    bus.dividend = 32'd90;
    bus.divisor  = 32'd4;
    waitDone("d77_5", n);
    checkOutput("d77_5", 32'd15, 32'd2, 1'b0);
    @(negedge clk);
    checkVal("held_gap_busy", bus.busy, 32'd0);
    @(negedge clk);
    checkVal("held_accept_busy", bus.busy, 32'd1);
    bus.start = 1'b0;
    waitDone("d90_4", n);
    checkVal("d90_4_latency", n, START_TO_DONE);
    checkOutput("d90_4", 32'd22, 32'd2, 1'b0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Parametrised, multi-cycle restoring divider for the datapath's DIV instruction.
- Retires one quotient bit per clock.
- Start/busy/done handshake to the control unit; quotient and remainder are written to the LO/HI registers by the control sequencer.
- Generalises the combinational 32-bit restoring divider: configurable width, registered iteration, divide-by-zero flag, optional signed mode.

Parameters:
- WIDTH, 32, operand/quotient/remainder width in bits (>= 4).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden).

Ports:
- clk  input  1  system clock, rising edge
- clr  input  1  synchronous active-high reset
- start  input  1  request a division; sampled only when busy=0
- dividend  input  WIDTH  dividend, captured on the accepted start
- divisor  input  WIDTH  divisor, captured on the accepted start
- busy  output  1  high while a division is in progress
- done  output  1  one-cycle pulse when results are valid
- div_by_zero  output  1  set with done when the captured divisor was 0; held until next accepted start
- quotient  output  WIDTH  quotient, held stable until next accepted start
- remainder  output  WIDTH  remainder, held stable until next accepted start

Behaviour:
- Reset: clk only; clr synchronous, active-high. Any clk edge with clr=1 forces IDLE. busy=0, done=0, div_by_zero=0, quotient=0, remainder=0, counter=0. An in-flight division is abandoned with no done.
- Internal registers:
  - A: WIDTH+1 bits, partial remainder.
  - Q: WIDTH bits, dividend/quotient shift register.
  - M: WIDTH bits, divisor.
- States: IDLE, RUN, FIX (exists only with DIV_SIGNED_EN), DONE.
- IDLE, start=1 at edge k:
  - Capture operands. A=0, Q=dividend (or |dividend| in signed mode), M=divisor (or |divisor|), counter=WIDTH.
  - busy=1 from edge k. div_by_zero cleared.
  - divisor==0 -> go to DONE directly.
  - Otherwise -> RUN.
- RUN, one iteration per edge:
  - {A,Q} shifted left 1.
  - A = A - M. If A[WIDTH]==1 (negative): restore A to its pre-subtract value, Q[0]=0. Else Q[0]=1.
  - counter decrements. After the edge where the counter reaches 0 -> DONE (unsigned) or FIX (signed).
- FIX (signed only, one cycle): apply sign correction to Q and A.
- DONE, one cycle:
  - quotient=Q, remainder=A[WIDTH-1:0], done=1 for exactly this cycle, busy=0 at the next edge, return to IDLE.
  - Divide-by-zero: quotient = all ones, remainder = dividend (as captured), div_by_zero=1.
- Latency, start sampled at edge k:
  - Unsigned: done high in cycle after edge k+WIDTH+1, i.e. WIDTH+2 cycles start-to-done.
  - Signed: WIDTH+3 cycles.
  - Divide-by-zero: done after edge k+1 in both modes.
- Back-to-back: start may be asserted in the done cycle. It is not accepted there (busy still 1); it is accepted on the following IDLE edge.
- start while busy=1 is ignored, with no effect on operands or state.
- Operands may change after acceptance without effect.
- Outputs never glitch. quotient/remainder change only on the DONE edge or on reset.
- Unsigned results: dividend = quotient*divisor + remainder, remainder < divisor.

Optional Feature:
- Macro: DIV_SIGNED_EN.
- Defined:
  - Operands are two's complement. Magnitudes are divided.
  - Quotient negated when operand signs differ. Remainder takes the dividend's sign (truncating division).
  - Most-negative / -1 yields quotient = most-negative, remainder = 0, no flag.
  - Divide-by-zero gives quotient all ones, remainder = dividend.
  - FIX state present.
- Not defined:
  - Unsigned only. FIX state and sign logic absent.
  - Latency WIDTH+2.

Test Plan:
- WIDTH=32 unsigned, dividend=100, divisor=7, start one cycle -> done exactly 34 cycles later (counted from the start cycle), quotient=14, remainder=2, div_by_zero=0; busy high for the intervening cycles.
- dividend=0xFFFFFFFF, divisor=1 -> quotient=0xFFFFFFFF, remainder=0. Then dividend=5, divisor=0xFFFFFFFF -> quotient=0, remainder=5.
- Divisor=0, dividend=0x1234 -> done 2 cycles after start, div_by_zero=1, quotient=0xFFFFFFFF, remainder=0x1234. Next valid division clears div_by_zero.
- clr asserted 10 cycles into a division -> next edge busy=0, quotient=remainder=0, no done pulse. New start then completes correctly.
- start re-pulsed while busy with different operands -> ignored, first result unchanged. Start held through done cycle -> second division accepted the cycle after done.
- DIV_SIGNED_EN:
  - -100/7 -> q=-14, r=-2.
  - 100/-7 -> q=-14, r=2.
  - 0x80000000/-1 -> q=0x80000000, r=0.
  - Done 35 cycles after start.
